hazard_unit_mc: RTL
===================

# hazard_unit_mc

Parametrised pipeline hazard controller for the 5-stage MIPS core, replacing the separate combinational forwarding and stall units with one block. It produces GPR forwarding selects for the EX stage and for ID-stage branch compare, and load-use and branch-dependency stalls gated by per-operand use flags. It also tracks a multi-cycle mult/div unit (MDU) with a latency counter, stalling HI/LO readers and new MDU ops until the result lands, and keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- REG_W, 5, GPR index width
- MUL_LAT, 4, MDU multiply latency in cycles (≥1)
- DIV_LAT, 32, MDU divide latency in cycles (≥1)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- id_rs, id_rt  in  REG_W  source regs of the instruction in ID
- id_use_rs, id_use_rt  in  1  ID instruction actually reads rs / rt
- id_is_branch  in  1  ID instruction is a branch/jr needing ID-stage compare
- id_rd_hilo  in  1  ID instruction is mfhi/mflo
- id_mdu_op  in  1  ID instruction is mult/multu/div/divu/mthi/mtlo
- ex_rs, ex_rt  in  REG_W  source regs in EX
- ex_rd  in  REG_W  destination in EX
- ex_rf_wr, ex_dm_rd  in  1  EX writes GPR / EX is a load
- mem_rd  in  REG_W; mem_rf_wr, mem_dm_rd  in  1  MEM-stage destination info
- wb_rd  in  REG_W; wb_rf_wr  in  1  WB-stage destination info
- ex_mdu_start  in  1  MDU op issues from EX this cycle
- ex_mdu_div  in  1  issued op is a divide (else multiply latency)
- flush  in  1  exception/eret flush of IF..EX
- fwd_a_ex, fwd_b_ex  out  2  EX operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB
- fwd_a_id, fwd_b_id  out  1  ID branch operand from EX/MEM
- pc_wr, if_id_wr  out  1  PC and IF/ID write enables
- id_ex_bubble  out  1  insert NOP into ID/EX
- mdu_busy  out  1  MDU result outstanding
- mdu_done  out  1  one-cycle pulse, MDU result written this cycle
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
- Register 0 never matches for forwarding or stall.
- EX forwarding: EX/MEM match with mem_rf_wr wins over MEM/WB match with wb_rf_wr. The same rule applies to rs→fwd_a_ex and rt→fwd_b_ex.
- ID forwarding: fwd_a_id = id_is_branch & mem_rf_wr & mem_rd==id_rs & id_use_rs. fwd_b_id follows the same rule for rt.
- Stall conditions, any of which forces pc_wr=0, if_id_wr=0, id_ex_bubble=1. Here dep(rd) = (rd!=0) & ((id_use_rs & rd==id_rs) | (id_use_rt & rd==id_rt)).
  - Load-use: ex_dm_rd & dep(ex_rd).
  - Branch on EX result: id_is_branch & ex_rf_wr & dep(ex_rd).
  - Branch on MEM load: id_is_branch & mem_dm_rd & dep(mem_rd).
  - MDU hazard: mdu_busy & (id_rd_hilo | id_mdu_op).
- flush forces pc_wr=1, if_id_wr=1, id_ex_bubble=0. Flush overrides all stalls.
- MDU counter: CW = clog2(DIV_LAT+1) bits.
  - ex_mdu_start & !flush loads the counter with DIV_LAT or MUL_LAT, selected by ex_mdu_div. A start while busy reloads.
  - Otherwise the counter decrements while non-zero.
  - mdu_busy = (counter != 0).
  - mdu_done is registered and goes high the cycle after the counter steps 1→0.
  - flush clears the counter to 0 and suppresses that done pulse.
- stall_cnt increments on each cycle with pc_wr=0. It saturates at 2^CNT_W−1 and never wraps.

## Timing
- Forwarding and stall outputs are combinational from the inputs and current state, with zero latency.
- ex_mdu_start sampled at edge E gives mdu_busy high for exactly LAT cycles after E. mdu_done is high during the following cycle, with mdu_busy already low.
- An ID HI/LO reader stalled on busy proceeds in the mdu_done cycle.
- Reset (rst high at edge): counter=0, mdu_busy=0, mdu_done=0, stall_cnt=0. The combinational outputs then follow the inputs. Reset mid-divide aborts the divide with no done pulse.
- Start and flush in the same cycle: flush wins, counter=0.

## Configuration
- HAZARD_BRANCH_FWD_EN defined: ID-stage branch forwarding from EX/MEM is active as described above.
- Undefined: fwd_a_id and fwd_b_id are tied 0. The branch-on-MEM condition becomes id_is_branch & (mem_rf_wr | mem_dm_rd) & dep(mem_rd), so any branch dependency in EX or MEM stalls.

## Test plan
- EX fwd priority: mem_rd=wb_rd=ex_rs=8, both writes set → fwd_a_ex=01. Drop mem_rf_wr → fwd_a_ex=10. Set ex_rs=0 → fwd_a_ex=00.
- Load-use with use flags: ex_dm_rd=1, ex_rd=5, id_rt=5, id_use_rt=0 → no stall. Set id_use_rt=1 → pc_wr=0, id_ex_bubble=1, and stall_cnt increments by 1.
- Branch after ALU op: id_is_branch, id_rs=3, ex_rf_wr, ex_rd=3 → 1 stall cycle. Next cycle with mem_rd=3 → fwd_a_id=1 and no stall, with the macro defined. Without the macro, stall for 2 cycles.
- Divide then mflo, DIV_LAT=32: start at edge E → mdu_busy for 32 cycles, and mflo in ID is stalled throughout. mdu_done is high on cycle 33 and mflo proceeds.
- Flush mid-divide: flush at cycle 10 of busy → counter 0 next cycle, and no mdu_done pulse.
- Saturation, CNT_W=4: hold a stall for 20 cycles → stall_cnt=15 and holds there. rst → 0.

Source files
------------

// File: rtl/hazard_unit_mc_if.sv
// Pipeline-to-hazard-controller bundle. The pipeline holds the master modport and the
// hazard controller holds the slave modport.
interface hazard_unit_mc_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  // ID stage
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_is_branch;
  logic             id_rd_hilo;
  logic             id_mdu_op;
  // EX stage
  logic [REG_W-1:0] ex_rs;
  logic [REG_W-1:0] ex_rt;
  logic [REG_W-1:0] ex_rd;
  logic             ex_rf_wr;
  logic             ex_dm_rd;
  logic             ex_mdu_start;
  logic             ex_mdu_div;
  // MEM / WB stages
  logic [REG_W-1:0] mem_rd;
  logic             mem_rf_wr;
  logic             mem_dm_rd;
  logic [REG_W-1:0] wb_rd;
  logic             wb_rf_wr;
  logic             flush;
  // Controller outputs
  logic [1:0]       fwd_a_ex;
  logic [1:0]       fwd_b_ex;
  logic             fwd_a_id;
  logic             fwd_b_id;
  logic             pc_wr;
  logic             if_id_wr;
  logic             id_ex_bubble;
  logic             mdu_busy;
  logic             mdu_done;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch, id_rd_hilo, id_mdu_op,
    output ex_rs, ex_rt, ex_rd, ex_rf_wr, ex_dm_rd, ex_mdu_start, ex_mdu_div,
    output mem_rd, mem_rf_wr, mem_dm_rd, wb_rd, wb_rf_wr, flush,
    input  fwd_a_ex, fwd_b_ex, fwd_a_id, fwd_b_id, pc_wr, if_id_wr, id_ex_bubble,
    input  mdu_busy, mdu_done, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch, id_rd_hilo, id_mdu_op,
    input  ex_rs, ex_rt, ex_rd, ex_rf_wr, ex_dm_rd, ex_mdu_start, ex_mdu_div,
    input  mem_rd, mem_rf_wr, mem_dm_rd, wb_rd, wb_rf_wr, flush,
    output fwd_a_ex, fwd_b_ex, fwd_a_id, fwd_b_id, pc_wr, if_id_wr, id_ex_bubble,
    output mdu_busy, mdu_done, stall_cnt
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// Unified hazard controller: GPR forwarding, load-use/branch/MDU stalls, MDU latency tracking
// and a saturating stall counter. Define HAZARD_BRANCH_FWD_EN to enable ID branch forwarding.
module hazard_unit_mc #(
  parameter int REG_W   = 5,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 16
) (
  input  logic            clk,
  input  logic            rst,
  hazard_unit_mc_if.slave hz
);
  localparam int              CW       = $clog2(DIV_LAT + 1);
  localparam logic [CW-1:0]   MUL_LOAD = CW'(MUL_LAT);
  localparam logic [CW-1:0]   DIV_LOAD = CW'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Operand 0 is rs, operand 1 is rt, in both ID and EX.
  logic [REG_W-1:0] id_src [2];
  logic             id_use [2];
  logic [REG_W-1:0] ex_src [2];
  logic [1:0]       fwd_ex [2];
  logic             fwd_id [2];
  logic             dep_ex [2];
  logic             dep_mem [2];

  assign id_src[0] = hz.id_rs;
  assign id_src[1] = hz.id_rt;
  assign id_use[0] = hz.id_use_rs;
  assign id_use[1] = hz.id_use_rt;
  assign ex_src[0] = hz.ex_rs;
  assign ex_src[1] = hz.ex_rt;

  logic ex_rd_nz;
  logic mem_rd_nz;
  logic wb_rd_nz;

  assign ex_rd_nz  = (hz.ex_rd  != '0);
  assign mem_rd_nz = (hz.mem_rd != '0);
  assign wb_rd_nz  = (hz.wb_rd  != '0);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
      logic mem_hit_ex;
      logic wb_hit_ex;

      assign mem_hit_ex = hz.mem_rf_wr & mem_rd_nz & (hz.mem_rd == ex_src[gi]);
      assign wb_hit_ex  = hz.wb_rf_wr  & wb_rd_nz  & (hz.wb_rd  == ex_src[gi]);
      // The younger EX/MEM result shadows the older MEM/WB one.
      assign fwd_ex[gi] = mem_hit_ex ? 2'b01 : (wb_hit_ex ? 2'b10 : 2'b00);

      assign dep_ex[gi]  = ex_rd_nz  & id_use[gi] & (hz.ex_rd  == id_src[gi]);
      assign dep_mem[gi] = mem_rd_nz & id_use[gi] & (hz.mem_rd == id_src[gi]);

`ifdef HAZARD_BRANCH_FWD_EN
      assign fwd_id[gi] = hz.id_is_branch & hz.mem_rf_wr & dep_mem[gi];
`else
      assign fwd_id[gi] = 1'b0;
`endif
    end
  endgenerate

  assign hz.fwd_a_ex = fwd_ex[0];
  assign hz.fwd_b_ex = fwd_ex[1];
  assign hz.fwd_a_id = fwd_id[0];
  assign hz.fwd_b_id = fwd_id[1];

  // ---------------------------------------------------------------- stall decision
  logic dep_ex_any;
  logic dep_mem_any;
  logic load_use;
  logic br_on_ex;
  logic br_on_mem;
  logic mdu_hz;
  logic stall_req;

  logic [CW-1:0] mdu_cnt_q;
  logic [CW-1:0] mdu_cnt_d;
  logic          mdu_done_q;
  logic          mdu_done_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic          mdu_busy;

  assign mdu_busy    = (mdu_cnt_q != '0);
  assign dep_ex_any  = dep_ex[0]  | dep_ex[1];
  assign dep_mem_any = dep_mem[0] | dep_mem[1];

  assign load_use = hz.ex_dm_rd & dep_ex_any;
  assign br_on_ex = hz.id_is_branch & hz.ex_rf_wr & dep_ex_any;
`ifdef HAZARD_BRANCH_FWD_EN
  // ALU results in MEM are forwarded to the compare; only a pending load must wait.
  assign br_on_mem = hz.id_is_branch & hz.mem_dm_rd & dep_mem_any;
`else
  assign br_on_mem = hz.id_is_branch & (hz.mem_rf_wr | hz.mem_dm_rd) & dep_mem_any;
`endif
  assign mdu_hz    = mdu_busy & (hz.id_rd_hilo | hz.id_mdu_op);
  assign stall_req = load_use | br_on_ex | br_on_mem | mdu_hz;

  logic pc_wr;
  logic if_id_wr;
  logic id_ex_bubble;

  // A flush redirects the front end, so it must never be held off by a stall.
  always_comb begin
    pc_wr        = 1'b1;
    if_id_wr     = 1'b1;
    id_ex_bubble = 1'b0;
    if (!hz.flush && stall_req) begin
      pc_wr        = 1'b0;
      if_id_wr     = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  assign hz.pc_wr        = pc_wr;
  assign hz.if_id_wr     = if_id_wr;
  assign hz.id_ex_bubble = id_ex_bubble;

  // ---------------------------------------------------------------- MDU latency tracker
  always_comb begin
    mdu_cnt_d  = mdu_cnt_q;
    mdu_done_d = 1'b0;
    if (hz.flush) begin
      mdu_cnt_d = '0;
    end else if (hz.ex_mdu_start) begin
      mdu_cnt_d = hz.ex_mdu_div ? DIV_LOAD : MUL_LOAD;
    end else if (mdu_busy) begin
      mdu_cnt_d  = mdu_cnt_q - 1'b1;
      mdu_done_d = (mdu_cnt_q == CW'(1));
    end
  end

  // ---------------------------------------------------------------- stall counter
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_wr && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mdu_cnt_q   <= '0;
      mdu_done_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      mdu_cnt_q   <= mdu_cnt_d;
      mdu_done_q  <= mdu_done_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.mdu_busy  = mdu_busy;
  assign hz.mdu_done  = mdu_done_q;
  assign hz.stall_cnt = stall_cnt_q;
endmodule
